mem_arbiter: RTL
================

# mem_arbiter

Parametrised arbiter that lets several CPU-side memory channels share one single-ported memory. It replaces the fixed point-to-point wiring between the core and separate instruction and data memories. The core's instruction fetch and data load/store ports can target one unified RAM with a configurable read latency. It supports fixed-priority or round-robin arbitration, issues at most one memory command per cycle, and routes each read return back to its originating channel.

## Interface
- NUM_PORTS, 2, number of requester channels (2..8); port 0 = data, port 1 = instruction by convention
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from a read being issued to mem_rdata valid (1..4)
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_PORTS  per-channel request
- we  in  NUM_PORTS  per-channel write enable (1 = write, 0 = read)
- addr  in  NUM_PORTS*ADDR_W  per-channel address, channel p at bits [p*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  per-channel write data, same packing
- gnt  out  NUM_PORTS  one-hot (or zero) grant, combinational in the accepting cycle
- rvalid  out  NUM_PORTS  one-hot (or zero) read-return strobe
- rdata  out  DATA_W  read data, shared, qualified by rvalid
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_read

## Operation
- Each cycle, the arbiter picks the winner among asserted req bits. At most one gnt bit is high. gnt is high only where req is high.
- Fixed mode: lowest asserted index wins.
- RR mode: search starts at priority pointer ptr. After a grant to port p, ptr <= (p+1) mod NUM_PORTS. ptr is unchanged when nothing is granted.
- On grant: mem_read = ~we[p], mem_write = we[p], mem_addr/mem_wdata = channel p fields. All combinational in the same cycle.
- No grant: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
- Requester holds req/we/addr/wdata stable until it sees gnt. The transaction is accepted on the clock edge where gnt is high.
- Writes complete at acceptance and produce no rvalid.
- Reads push {valid, port tag} into a MEM_LATENCY-deep shift pipeline.
  - When the tail entry is valid with tag p, rvalid[p] = 1 and rdata = mem_rdata (combinational passthrough).
  - Otherwise rvalid = 0 and rdata = 0.
- Fully pipelined: one new read per cycle, up to MEM_LATENCY reads in flight. Returns are in issue order.
- A channel may issue again the cycle after its grant, without waiting for rvalid.

## Timing
- Reset values (async, while reset high): gnt = 0, rvalid = 0, rdata = 0, mem_read = 0, mem_write = 0, ptr = 0, all pipeline entries invalid.
- Grant latency: 0 cycles; a request is granted in the cycle it first wins.
- Read latency: a read accepted at edge N raises rvalid in the cycle following edge N+MEM_LATENCY-1, i.e. MEM_LATENCY cycles after the grant cycle.
- Simultaneous grant and return in one cycle: both are legal and independent. Returning data belongs to the older read.
- Fairness in RR mode: with all NUM_PORTS requesting continuously, each port is granted exactly once every NUM_PORTS cycles.
- Reset asserted mid-operation: in-flight reads are discarded. No rvalid for them after reset deasserts. ptr returns to 0.
- ptr wraps from NUM_PORTS-1 to 0.

## Structure
- Shared package mem_bus_pkg holds:
  - PORT_DMEM = 0, PORT_IMEM = 1
  - MAX_MEM_LATENCY = 4
  - tag width function clog2(NUM_PORTS), minimum 1
- Sub-module rr_arbiter: request vector, pointer and mode in; one-hot grant and next pointer out. Parametrised by NUM_PORTS.
- The return pipeline and pointer register live in mem_arbiter.

## Test plan
- Fixed mode, MEM_LATENCY = 1:
  - req = 2'b11, port 0 read of 0x10, port 1 read of 0x20 -> gnt = 01, mem_addr = 0x10.
  - Next cycle: gnt = 10, rvalid = 01 with mem_rdata.
  - Following cycle: rvalid = 10.
- RR mode, NUM_PORTS = 4, all req held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3.
- MEM_LATENCY = 3, port 1 issues back-to-back reads to 0x0, 0x4, 0x8 -> rvalid[1] on 3 consecutive cycles starting 3 cycles after the first grant; rdata matches memory contents in order.
- Port 0 write 0xDEADBEEF to 0x40, then port 1 read of 0x40 -> mem_write then mem_read; port 1 rdata = 0xDEADBEEF; no rvalid for the write.
- MEM_LATENCY = 2, reset asserted for 1 cycle while 2 reads are in flight -> all outputs 0 immediately; no rvalid afterwards; RR ptr = 0.
- req = 0 for 5 cycles -> mem_read = mem_write = 0, gnt = 0, ptr unchanged.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the CPU-side memory arbiter.
// Holds the channel numbering, latency ceiling, arbitration modes and tag sizing.
package mem_bus_pkg;

  localparam int PORT_DMEM       = 0;
  localparam int PORT_IMEM       = 1;
  localparam int MAX_MEM_LATENCY = 4;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // A single requester still needs a 1-bit tag.
  function automatic int tag_w(input int num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester channels plus the single-ported memory command/return bus.
// slave = arbiter view, master = requesters and memory.
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Picks one requester: lowest index (fixed) or first at/after ptr (round-robin).
// Purely combinational, 0 cycles; a losing request simply sees no grant.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = tag_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [TAG_W-1:0]     ptr,
  input  arb_mode_e            mode,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 win_vld,
  output logic [TAG_W-1:0]     win_idx,
  output logic [TAG_W-1:0]     ptr_next
);

  logic [TAG_W-1:0] start;
  logic [TAG_W-1:0] idx;

  always_comb begin
    gnt      = '0;
    win_vld  = 1'b0;
    win_idx  = '0;
    ptr_next = ptr;
    idx      = '0;
    start    = (mode == ARB_RR) ? ptr : '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = TAG_W'((int'(start) + k) % NUM_PORTS);
      if (!win_vld && req[idx]) begin
        win_vld  = 1'b1;
        win_idx  = idx;
        gnt[idx] = 1'b1;
        ptr_next = (int'(idx) == NUM_PORTS - 1) ? '0 : TAG_W'(int'(idx) + 1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory among NUM_PORTS channels, one command per cycle.
// Grant is same-cycle; read data returns MEM_LATENCY cycles later in issue order.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int RR_MODE     = 0
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int        TAG_W = tag_w(NUM_PORTS);
  localparam arb_mode_e MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } ret_t;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic                 win_vld;
  logic [TAG_W-1:0]     win_idx;
  logic [TAG_W-1:0]     ptr;
  logic [TAG_W-1:0]     ptr_next;
  logic                 issue;
  ret_t                 pipe [MEM_LATENCY];
  ret_t                 tail;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .TAG_W     (TAG_W)
  ) u_arb (
    .req      (bus.req),
    .ptr      (ptr),
    .mode     (MODE),
    .gnt      (arb_gnt),
    .win_vld  (win_vld),
    .win_idx  (win_idx),
    .ptr_next (ptr_next)
  );

  // Nothing may be accepted while reset is held, even though req is live.
  assign issue   = win_vld & ~reset;
  assign bus.gnt = issue ? arb_gnt : '0;

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (issue) begin
      bus.mem_read  = ~bus.we[win_idx];
      bus.mem_write = bus.we[win_idx];
      bus.mem_addr  = bus.addr[int'(win_idx)*ADDR_W +: ADDR_W];
      bus.mem_wdata = bus.wdata[int'(win_idx)*DATA_W +: DATA_W];
    end
  end

  // Tag pipeline mirrors the memory's read latency; writes leave a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (win_vld && MODE == ARB_RR) ptr <= ptr_next;
      pipe[0] <= '{vld: win_vld & ~bus.we[win_idx], tag: win_idx};
      for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[MEM_LATENCY-1];

  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    if (tail.vld) begin
      bus.rvalid[tail.tag] = 1'b1;
      bus.rdata            = bus.mem_rdata;
    end
  end

endmodule
